apb_exe_master_arb: RTL and testbench
=====================================

// Module: apb_exe_master_arb
// PURPOSE
//  APB master that shares the execution-unit slaves among NREQ requesters. Round-robin arbitration.
//  Per granted request: APB write (PADDR=oper, PWDATA={argB,argA}), fixed execution wait,
//  then APB read returning result and status. Sits between compute clients and the APB slave bus.
// PARAMETERS
//  NREQ        4   number of requesters
//  SEL_WIDTH   3   PSEL width, one bit per slave
//  ADDR_WIDTH  2   PADDR width (= operation code width)
//  DATA_WIDTH  32  PWDATA/PRDATA width; args and result are DATA_WIDTH/2
//  EXEC_WAIT   2   idle cycles between write completion and read SETUP
//  TIMEOUT     16  max ACCESS cycles waiting for PREADY
// PORTS
//  i_PCLK       in   1                  clock
//  i_PRESET     in   1                  reset, synchronous, active-high
//  i_req        in   NREQ               request per requester; held high until its o_done
//  i_req_oper   in   NREQ*ADDR_WIDTH    operation code, slice r = requester r
//  i_req_argA   in   NREQ*DATA_WIDTH/2  operand A
//  i_req_argB   in   NREQ*DATA_WIDTH/2  operand B
//  i_req_slv    in   NREQ*$clog2(SEL_WIDTH)  target slave index
//  o_gnt        out  NREQ               one-hot, high from grant until DONE
//  o_done       out  NREQ               one-hot, 1-cycle pulse in DONE
//  o_result     out  DATA_WIDTH/2       captured PRDATA[DATA_WIDTH/2-1:0], valid with o_done
//  o_status     out  4                  captured PSLVERR, valid with o_done
//  o_timeout    out  1                  high with o_done if the transaction timed out
//  o_PSEL       out  SEL_WIDTH          one-hot slave select
//  o_PENABLE    out  1  ;  o_PWRITE out 1  ;  o_PADDR out ADDR_WIDTH  ;  o_PWDATA out DATA_WIDTH
//  i_PREADY     in   1  ;  i_PSLVERR in 4  ;  i_PRDATA in DATA_WIDTH
// BEHAVIOUR
//  Reset: state IDLE; RR pointer 0; all outputs 0.
//  FSM: IDLE -> W_SETUP -> W_ACCESS -> EXEC -> R_SETUP -> R_ACCESS -> DONE -> IDLE.
//  IDLE: if |i_req, pick first requesting index at or after RR pointer (wrap at NREQ).
//   Latch oper/args/slave of grantee. Assert o_gnt. Go to W_SETUP. Fields are sampled only here.
//  W_SETUP: PSEL=1<<slv, PWRITE=1, PENABLE=0, PADDR=oper, PWDATA={argB,argA}.
//  W_ACCESS: same, PENABLE=1. On i_PREADY=1 go to EXEC.
//  EXEC: PSEL=0, PENABLE=0 for EXEC_WAIT cycles. EXEC_WAIT=0 goes straight to R_SETUP.
//  R_SETUP: PSEL asserted, PWRITE=0, PENABLE=0. Any i_PREADY seen here is stale and ignored.
//  R_ACCESS: PENABLE=1. On i_PREADY=1 capture PRDATA low half into o_result and PSLVERR into
//   o_status, then go to DONE.
//  DONE: PSEL/PENABLE=0; pulse o_done[grantee]; RR pointer = grantee+1 (mod NREQ); drop o_gnt.
//  Timeout: ACCESS cycle counter resets on entry to each ACCESS. At TIMEOUT cycles without
//   PREADY: go to DONE with o_timeout=1, o_result=0, o_status=4'hF.
//  Latency with zero-wait slave, registered PREADY, EXEC_WAIT=2: req in IDLE cycle 0 -> o_done in cycle 9.
//  Widths: o_result is PRDATA[DATA_WIDTH/2-1:0]; upper half ignored.
//   Slave index >= SEL_WIDTH -> no PSEL bit; resolves by timeout.
//  Requests arriving while busy wait; i_req dropped after grant is ignored and the transaction completes.
//  Simultaneous requests: exactly one grant per transaction; no requester starves (max NREQ-1 waits).
//  Reset mid-transaction: back to IDLE next edge; PSEL/PENABLE low; no o_done emitted.
// STRUCTURE
//  Package apb_ctrl_pkg: state_t enum (IDLE,W_SETUP,W_ACCESS,EXEC,R_SETUP,R_ACCESS,DONE), STATUS_TIMEOUT=4'hF.
//  Sub-module rr_arbiter #(N): i_req, i_ptr -> one-hot o_gnt and index; combinational.
//  FSM, counters and APB drive live in this module.
// TESTING
//  1. Single req r0, oper=1, A=16'h0005, B=16'h0003, slv=1
//     -> PSEL=3'b010, PWDATA=32'h00030005, PADDR=1; o_done[0] in cycle 9 with slave result.
//  2. All 4 req high from reset -> grants in order 0,1,2,3,0; each o_done one-hot, no overlap.
//  3. Slave never asserts PREADY -> after 16 ACCESS cycles o_done with o_timeout=1, o_status=4'hF, o_result=0.
//  4. Slave PSLVERR=4'b0100 on read -> o_status=4'b0100 with o_done; o_timeout=0.
//  5. i_PRESET asserted in R_ACCESS -> next cycle PSEL=0, PENABLE=0, o_gnt=0, no o_done;
//     held req re-granted after release.
//  6. r2 drops req in W_ACCESS -> transaction completes, o_done[2] pulses, RR pointer=3.

Source files
------------

// File: rtl/apb_exe_master_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_ctrl_pkg
// Brief    : Shared types and constants for the APB execution-unit master.
// Revision : 1.0
// ============================================================================
package apb_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_SETUP  = 3'd1,
        W_ACCESS = 3'd2,
        EXEC     = 3'd3,
        R_SETUP  = 3'd4,
        R_ACCESS = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam logic [3:0] STATUS_TIMEOUT = 4'hF;

    // Index width that stays legal for single-entry vectors.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_exe_master_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_exe_master_arb_if
// Brief    : Requester-side and APB-side signal bundle of the arbitrating master.
// Revision : 1.0
// ============================================================================
interface apb_exe_master_arb_if #(
    parameter int NREQ       = 4,
    parameter int SEL_WIDTH  = 3,
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 32
);
    localparam int HALF_W = DATA_WIDTH / 2;
    localparam int SLV_W  = apb_ctrl_pkg::idx_width(SEL_WIDTH);

    logic [NREQ-1:0]            i_req;
    logic [NREQ*ADDR_WIDTH-1:0] i_req_oper;
    logic [NREQ*HALF_W-1:0]     i_req_argA;
    logic [NREQ*HALF_W-1:0]     i_req_argB;
    logic [NREQ*SLV_W-1:0]      i_req_slv;
    logic [NREQ-1:0]            o_gnt;
    logic [NREQ-1:0]            o_done;
    logic [HALF_W-1:0]          o_result;
    logic [3:0]                 o_status;
    logic                       o_timeout;

    logic [SEL_WIDTH-1:0]       o_PSEL;
    logic                       o_PENABLE;
    logic                       o_PWRITE;
    logic [ADDR_WIDTH-1:0]      o_PADDR;
    logic [DATA_WIDTH-1:0]      o_PWDATA;
    logic                       i_PREADY;
    logic [3:0]                 i_PSLVERR;
    logic [DATA_WIDTH-1:0]      i_PRDATA;

    modport master (
        input  i_req, i_req_oper, i_req_argA, i_req_argB, i_req_slv,
        input  i_PREADY, i_PSLVERR, i_PRDATA,
        output o_gnt, o_done, o_result, o_status, o_timeout,
        output o_PSEL, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA
    );

    modport slave (
        output i_req, i_req_oper, i_req_argA, i_req_argB, i_req_slv,
        output i_PREADY, i_PSLVERR, i_PRDATA,
        input  o_gnt, o_done, o_result, o_status, o_timeout,
        input  o_PSEL, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA
    );

endinterface
`default_nettype wire

// File: rtl/apb_exe_master_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first request at or after i_ptr.
// Revision : 1.0
// ============================================================================
module rr_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  wire logic [N-1:0]               i_req,
    input  wire logic [idx_width(N)-1:0]    i_ptr,
    output logic      [N-1:0]               o_gnt,
    output logic      [idx_width(N)-1:0]    o_idx,
    output logic                            o_valid
);
    localparam int c_iw = idx_width(N);

    logic [c_iw-1:0] w_cand;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = c_iw'((int'(i_ptr) + k) % N);
            if (!o_valid && i_req[w_cand]) begin
                o_valid       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_exe_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : apb_exe_master_arb
// Brief    : Round-robin APB master: write operands, wait, read result per grant.
// Revision : 1.0
// ============================================================================
module apb_exe_master_arb
    import apb_ctrl_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int SEL_WIDTH  = 3,
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 32,
    parameter int EXEC_WAIT  = 2,
    parameter int TIMEOUT    = 16
) (
    input  wire logic               i_PCLK,
    input  wire logic               i_PRESET,
    apb_exe_master_arb_if.master    bus
);
    localparam int c_iw      = idx_width(NREQ);
    localparam int c_sw      = idx_width(SEL_WIDTH);
    localparam int c_half    = DATA_WIDTH / 2;
    localparam int c_cnt_max = (TIMEOUT > EXEC_WAIT) ? TIMEOUT : EXEC_WAIT;
    localparam int c_cw      = $clog2(c_cnt_max + 1);

    localparam logic [c_cw-1:0] c_to_last   = c_cw'(TIMEOUT - 1);
    localparam logic [c_cw-1:0] c_exec_last = (EXEC_WAIT > 0) ? c_cw'(EXEC_WAIT - 1) : '0;

    state_t                 r_state;
    state_t                 w_next;

    logic [NREQ-1:0]        w_arb_gnt;
    logic [c_iw-1:0]        w_arb_idx;
    logic                   w_arb_valid;

    logic [c_iw-1:0]        r_ptr;
    logic [c_iw-1:0]        r_idx;
    logic [NREQ-1:0]        r_gnt_oh;
    logic [ADDR_WIDTH-1:0]  r_oper;
    logic [c_half-1:0]      r_arg_a;
    logic [c_half-1:0]      r_arg_b;
    logic [c_sw-1:0]        r_slv;
    logic [c_cw-1:0]        r_cnt;
    logic [c_half-1:0]      r_result;
    logic [3:0]             r_status;
    logic                   r_timeout;

    logic [SEL_WIDTH-1:0]   w_psel_dec;
    logic                   w_access;
    logic                   w_to_hit;
    logic                   w_unused_prdata_hi;

    rr_arbiter #(
        .N       (NREQ)
    ) u_arb (
        .i_req   (bus.i_req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    // An out-of-range slave index selects nothing; the access then times out.
    always_comb begin
        w_psel_dec = '0;
        for (int s = 0; s < SEL_WIDTH; s++) begin
            if (r_slv == c_sw'(s)) begin
                w_psel_dec[s] = 1'b1;
            end
        end
    end

    assign w_access           = (r_state == W_ACCESS) || (r_state == R_ACCESS);
    assign w_to_hit           = w_access && !bus.i_PREADY && (r_cnt == c_to_last);
    assign w_unused_prdata_hi = ^bus.i_PRDATA[DATA_WIDTH-1:c_half];

    always_ff @(posedge i_PCLK) begin
        if (i_PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        bus.o_PSEL     = '0;
        bus.o_PENABLE  = 1'b0;
        bus.o_PWRITE   = 1'b0;
        bus.o_PADDR    = '0;
        bus.o_PWDATA   = '0;
        bus.o_gnt      = '0;
        bus.o_done     = '0;
        bus.o_timeout  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_next = W_SETUP;
                end
            end
            W_SETUP: begin
                bus.o_PSEL   = w_psel_dec;
                bus.o_PWRITE = 1'b1;
                bus.o_PADDR  = r_oper;
                bus.o_PWDATA = {r_arg_b, r_arg_a};
                bus.o_gnt    = r_gnt_oh;
                w_next       = W_ACCESS;
            end
            W_ACCESS: begin
                bus.o_PSEL    = w_psel_dec;
                bus.o_PENABLE = 1'b1;
                bus.o_PWRITE  = 1'b1;
                bus.o_PADDR   = r_oper;
                bus.o_PWDATA  = {r_arg_b, r_arg_a};
                bus.o_gnt     = r_gnt_oh;
                if (bus.i_PREADY) begin
                    w_next = (EXEC_WAIT == 0) ? R_SETUP : EXEC;
                end else if (w_to_hit) begin
                    w_next = DONE;
                end
            end
            EXEC: begin
                bus.o_gnt = r_gnt_oh;
                if (r_cnt == c_exec_last) begin
                    w_next = R_SETUP;
                end
            end
            R_SETUP: begin
                bus.o_PSEL  = w_psel_dec;
                bus.o_PADDR = r_oper;
                bus.o_gnt   = r_gnt_oh;
                w_next      = R_ACCESS;
            end
            R_ACCESS: begin
                bus.o_PSEL    = w_psel_dec;
                bus.o_PENABLE = 1'b1;
                bus.o_PADDR   = r_oper;
                bus.o_gnt     = r_gnt_oh;
                if (bus.i_PREADY || w_to_hit) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                bus.o_done    = r_gnt_oh;
                bus.o_timeout = r_timeout;
                w_next        = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Request fields are only sampled at grant; later changes on the inputs are ignored.
    always_ff @(posedge i_PCLK) begin
        if (i_PRESET) begin
            r_ptr     <= '0;
            r_idx     <= '0;
            r_gnt_oh  <= '0;
            r_oper    <= '0;
            r_arg_a   <= '0;
            r_arg_b   <= '0;
            r_slv     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_status  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if ((w_next == r_state) && (w_access || (r_state == EXEC))) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if ((r_state == IDLE) && w_arb_valid) begin
                r_gnt_oh  <= w_arb_gnt;
                r_idx     <= w_arb_idx;
                r_oper    <= bus.i_req_oper[int'(w_arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                r_arg_a   <= bus.i_req_argA[int'(w_arb_idx)*c_half +: c_half];
                r_arg_b   <= bus.i_req_argB[int'(w_arb_idx)*c_half +: c_half];
                r_slv     <= bus.i_req_slv[int'(w_arb_idx)*c_sw +: c_sw];
                r_timeout <= 1'b0;
            end

            if (w_to_hit) begin
                r_timeout <= 1'b1;
                r_result  <= '0;
                r_status  <= STATUS_TIMEOUT;
            end else if ((r_state == R_ACCESS) && bus.i_PREADY) begin
                r_result  <= bus.i_PRDATA[c_half-1:0];
                r_status  <= bus.i_PSLVERR;
            end

            if (r_state == DONE) begin
                r_ptr <= (int'(r_idx) == NREQ - 1) ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign bus.o_result = r_result;
    assign bus.o_status = r_status;

endmodule
`default_nettype wire

// File: tb/tb_apb_exe_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_exe_master_arb
// Brief    : Directed plus randomized bench with an execution-unit slave model.
// Revision : 1.0
// ============================================================================
module tb_apb_exe_master_arb;
    import apb_ctrl_pkg::*;

    localparam int NREQ = 4, SEL_WIDTH = 3, ADDR_WIDTH = 2, DATA_WIDTH = 32;
    localparam int EXEC_WAIT = 2, TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_exe_master_arb_if #(
        .NREQ(NREQ), .SEL_WIDTH(SEL_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) bus ();

    apb_exe_master_arb #(
        .NREQ(NREQ), .SEL_WIDTH(SEL_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .EXEC_WAIT(EXEC_WAIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_PCLK   (clk),
        .i_PRESET (rst),
        .bus      (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int m_ptr   = 0;
    bit gnt_bad = 1'b0;

    logic [1:0]  f_oper [NREQ];
    logic [15:0] f_a    [NREQ];
    logic [15:0] f_b    [NREQ];
    logic [1:0]  f_slv  [NREQ];

    function automatic logic [15:0] exec_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        case (op)
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a * b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    // Slave: registered zero-wait PREADY, computes the operation on the written operands.
    logic        slv_dead = 1'b0;
    logic [3:0]  slv_err  = 4'h0;
    logic [31:0] slv_wdata = '0;
    logic [1:0]  slv_oper  = '0;
    logic [15:0] slv_hi    = '0;

    always @(posedge clk) begin
        if (rst) bus.i_PREADY <= 1'b0;
        else     bus.i_PREADY <= !slv_dead && (|bus.o_PSEL) && bus.o_PENABLE && !bus.i_PREADY;
        if ((|bus.o_PSEL) && bus.o_PENABLE && bus.o_PWRITE && !bus.i_PREADY) begin
            slv_wdata <= bus.o_PWDATA;
            slv_oper  <= bus.o_PADDR;
            slv_hi    <= 16'($urandom);
        end
    end
    assign bus.i_PRDATA  = {slv_hi, exec_op(slv_oper, slv_wdata[15:0], slv_wdata[31:16])};
    assign bus.i_PSLVERR = (bus.o_PENABLE && !bus.o_PWRITE) ? slv_err : 4'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_fields(input int r, input logic [1:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic [1:0] s);
        f_oper[r] = op; f_a[r] = a; f_b[r] = b; f_slv[r] = s;
        bus.i_req_oper[r*2 +: 2]  = op;
        bus.i_req_argA[r*16 +: 16] = a;
        bus.i_req_argB[r*16 +: 16] = b;
        bus.i_req_slv[r*2 +: 2]   = s;
    endtask

    task automatic rand_fields(input int r);
        set_fields(r, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 2'($urandom_range(0, 2)));
    endtask

    // Reference arbitration: first pending requester at or after the pointer, wrapping.
    function automatic int rr_pick(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic wait_done(output int idx, output int cyc);
        idx = -1;
        cyc = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (!$onehot0(bus.o_gnt)) gnt_bad = 1'b1;
            if (bus.o_done != '0) begin
                cyc = c;
                for (int r = 0; r < NREQ; r++) if (bus.o_done[r]) idx = r;
                return;
            end
        end
    endtask

    // Checks one completion against the model and advances the model pointer.
    task automatic check_txn(input string tag, input int got, input int exp, input logic exp_to,
                             input logic [3:0] exp_st, input logic [15:0] exp_res);
        chk({tag, "_idx"}, got, exp);
        chk({tag, "_done1h"}, $countones(bus.o_done), 1);
        chk({tag, "_gnt_low"}, bus.o_gnt, '0);
        chk({tag, "_timeout"}, bus.o_timeout, exp_to);
        chk({tag, "_status"}, bus.o_status, exp_st);
        chk({tag, "_result"}, bus.o_result, exp_res);
        if (exp >= 0) m_ptr = (exp + 1) % NREQ;
    endtask

    initial begin
        int idx, cyc, exp;
        logic [3:0] pend, add;

        bus.i_req = '0;
        bus.i_req_oper = '0; bus.i_req_argA = '0; bus.i_req_argB = '0; bus.i_req_slv = '0;
        for (int r = 0; r < NREQ; r++) rand_fields(r);
        bus.i_req = 4'hF;
        repeat (3) @(negedge clk);

        chk("rst_gnt", bus.o_gnt, '0);
        chk("rst_done", bus.o_done, '0);
        chk("rst_psel", bus.o_PSEL, '0);
        chk("rst_penable", bus.o_PENABLE, 0);
        chk("rst_pwrite", bus.o_PWRITE, 0);
        chk("rst_pwdata", bus.o_PWDATA, '0);
        chk("rst_result", bus.o_result, '0);
        chk("rst_status", bus.o_status, '0);
        chk("rst_timeout", bus.o_timeout, 0);

        // All four requesting from reset; r0 keeps requesting and must come round again.
        rst = 1'b0;
        pend = 4'hF;
        for (int t = 0; t < 5; t++) begin
            wait_done(idx, cyc);
            exp = rr_pick(pend, m_ptr);
            check_txn("all4", idx, exp, 1'b0, 4'h0,
                      (exp >= 0) ? exec_op(f_oper[exp], f_a[exp], f_b[exp]) : 16'h0);
            if (idx >= 0) begin
                if (t == 4 || idx != 0) pend[idx] = 1'b0;
                else rand_fields(0);
            end
            bus.i_req = pend;
        end
        @(negedge clk);

        // Single request, latency and write-phase bus values.
        set_fields(0, 2'd1, 16'h0005, 16'h0003, 2'd1);
        bus.i_req = 4'b0001;
        @(negedge clk);
        chk("t1_psel", bus.o_PSEL, 3'b010);
        chk("t1_pwrite", bus.o_PWRITE, 1);
        chk("t1_penable", bus.o_PENABLE, 0);
        chk("t1_paddr", bus.o_PADDR, 2'd1);
        chk("t1_pwdata", bus.o_PWDATA, 32'h00030005);
        chk("t1_gnt", bus.o_gnt, 4'b0001);
        wait_done(idx, cyc);
        chk("t1_latency", cyc + 1, 9);
        check_txn("t1", idx, 0, 1'b0, 4'h0, 16'h0002);
        bus.i_req = '0;
        @(negedge clk);

        // Slave never ready: timeout after TIMEOUT write-ACCESS cycles.
        slv_dead = 1'b1;
        set_fields(1, 2'd0, 16'h1111, 16'h2222, 2'd0);
        bus.i_req = 4'b0010;
        wait_done(idx, cyc);
        chk("t3_latency", cyc, 2 + TIMEOUT);
        check_txn("t3", idx, 1, 1'b1, STATUS_TIMEOUT, 16'h0);
        bus.i_req = '0;
        slv_dead = 1'b0;
        @(negedge clk);

        // Slave index beyond SEL_WIDTH: no PSEL bit, resolves by timeout.
        set_fields(2, 2'd3, 16'h00FF, 16'h0F0F, 2'd3);
        bus.i_req = 4'b0100;
        @(negedge clk);
        chk("t3b_psel", bus.o_PSEL, '0);
        wait_done(idx, cyc);
        check_txn("t3b", idx, 2, 1'b1, STATUS_TIMEOUT, 16'h0);
        bus.i_req = '0;
        @(negedge clk);

        // PSLVERR on the read is reported as status.
        slv_err = 4'b0100;
        set_fields(3, 2'd2, 16'h0007, 16'h0009, 2'd2);
        bus.i_req = 4'b1000;
        @(negedge clk);
        chk("t4_psel", bus.o_PSEL, 3'b100);
        wait_done(idx, cyc);
        check_txn("t4", idx, 3, 1'b0, 4'b0100, 16'd63);
        bus.i_req = '0;
        slv_err = 4'h0;
        @(negedge clk);

        // r2 withdraws during W_ACCESS; the transaction still completes.
        set_fields(2, 2'd0, 16'h1234, 16'h0101, 2'd0);
        bus.i_req = 4'b0100;
        for (int c = 0; c < 20 && !(bus.o_PENABLE && bus.o_PWRITE); c++) @(negedge clk);
        chk("t6_in_waccess", bus.o_PENABLE && bus.o_PWRITE, 1);
        bus.i_req = '0;
        wait_done(idx, cyc);
        check_txn("t6", idx, 2, 1'b0, 4'h0, 16'h1335);
        set_fields(0, 2'd3, 16'hA5A5, 16'h0F0F, 2'd1);
        set_fields(3, 2'd0, 16'h0001, 16'h0001, 2'd2);
        pend = 4'b1001;
        bus.i_req = pend;
        for (int t = 0; t < 2; t++) begin
            wait_done(idx, cyc);
            exp = rr_pick(pend, m_ptr);
            check_txn("t6_after", idx, exp, 1'b0, 4'h0,
                      (exp >= 0) ? exec_op(f_oper[exp], f_a[exp], f_b[exp]) : 16'h0);
            if (idx >= 0) pend[idx] = 1'b0;
            bus.i_req = pend;
        end
        @(negedge clk);

        // Reset during R_ACCESS aborts silently; the held request is served afterwards.
        set_fields(1, 2'd2, 16'h0010, 16'h0020, 2'd0);
        bus.i_req = 4'b0010;
        for (int c = 0; c < 20 && !((|bus.o_PSEL) && bus.o_PENABLE && !bus.o_PWRITE); c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_psel", bus.o_PSEL, '0);
        chk("t5_penable", bus.o_PENABLE, 0);
        chk("t5_gnt", bus.o_gnt, '0);
        chk("t5_done", bus.o_done, '0);
        m_ptr = 0;
        rst = 1'b0;
        wait_done(idx, cyc);
        check_txn("t5_regrant", idx, 1, 1'b0, 4'h0, 16'h0200);
        bus.i_req = '0;
        @(negedge clk);

        // Randomized arrivals checked against the reference arbitration order.
        pend = '0;
        for (int n = 0; n < 24; n++) begin
            add = (n < 16) ? (4'($urandom) & ~pend) : 4'h0;
            if (pend == 4'h0 && add == 4'h0) add = 4'b0001 << $urandom_range(0, 3);
            for (int r = 0; r < NREQ; r++) if (add[r]) rand_fields(r);
            pend |= add;
            bus.i_req = pend;
            wait_done(idx, cyc);
            exp = rr_pick(pend, m_ptr);
            check_txn("rnd", idx, exp, 1'b0, 4'h0,
                      (exp >= 0) ? exec_op(f_oper[exp], f_a[exp], f_b[exp]) : 16'h0);
            if (idx >= 0) pend[idx] = 1'b0;
            bus.i_req = pend;
            if (n >= 16 && pend == 4'h0) break;
        end

        chk("gnt_onehot", gnt_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
